// File: rtl/noise_lfsr_multi_pkg.sv
// Shared PSG noise definitions: mode encodings and the classic AY LFSR defaults.
package noise_lfsr_multi_pkg;

  localparam logic NOISE_WHITE    = 1'b0;
  localparam logic NOISE_PERIODIC = 1'b1;

  localparam int          AY_LFSR_BITS = 17;
  localparam logic [16:0] AY_TAP_MASK  = 17'h00009;
  localparam logic [16:0] AY_SEED      = 17'h00001;

  // Divider terminal count: a period of 0 behaves like a period of 1.
  function automatic logic [15:0] period_last(input logic [15:0] period);
    logic [15:0] last;
    if (period == 16'd0) begin
      last = 16'd0;
    end else begin
      last = period - 16'd1;
    end
    return last;
  endfunction

endpackage

// File: rtl/noise_lfsr_multi_divider.sv
// Noise rate generator: enable prescaler, period counter and half-rate toggle.
module noise_lfsr_multi_divider
  import noise_lfsr_multi_pkg::*;
#(
  parameter int PERIOD_BITS = 5,
  parameter int PRESCALE    = 16,
  parameter bit HALF_RATE   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [PERIOD_BITS-1:0] i_period,
  input  logic                   i_clear,
  output logic                   o_shift_req
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]       r_pre;
  logic [PERIOD_BITS-1:0] r_cnt;
  logic                   r_toggle;

  logic                   w_div_tick;
  logic [PERIOD_BITS-1:0] w_period_last;
  logic                   w_wrap;

  // Decode prescaler wrap, effective period and the shift request
  always_comb begin
    w_div_tick    = i_enable & (r_pre == PRE_LAST);
    w_period_last = PERIOD_BITS'(period_last(16'(i_period)));
    // >= rather than == so a period lowered mid-count wraps immediately.
    w_wrap        = w_div_tick & (r_cnt >= w_period_last);
    if (i_clear) begin
      o_shift_req = 1'b0;
    end else if (HALF_RATE) begin
      o_shift_req = w_wrap & ~r_toggle;
    end else begin
      o_shift_req = w_wrap;
    end
  end

  // Prescaler, period counter and half-rate toggle state
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_pre    <= {PRE_W{1'b0}};
      r_cnt    <= {PERIOD_BITS{1'b0}};
      r_toggle <= 1'b0;
    end else if (i_enable) begin
      if (w_div_tick) begin
        r_pre <= {PRE_W{1'b0}};
        if (w_wrap) begin
          r_cnt    <= {PERIOD_BITS{1'b0}};
          r_toggle <= ~r_toggle;
        end else begin
          r_cnt <= r_cnt + PERIOD_BITS'(1);
        end
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/noise_lfsr_multi.sv
// PSG noise channel: configurable LFSR with white/periodic feedback and a private divider.
module noise_lfsr_multi
  import noise_lfsr_multi_pkg::*;
#(
  parameter int                   LFSR_BITS   = 17,
  parameter logic [LFSR_BITS-1:0] TAP_MASK    = LFSR_BITS'(AY_TAP_MASK),
  parameter logic [LFSR_BITS-1:0] SEED        = LFSR_BITS'(AY_SEED),
  parameter int                   PERIOD_BITS = 5,
  parameter int                   PRESCALE    = 16,
  parameter bit                   HALF_RATE   = 1'b1,
  parameter bit                   OUT_INVERT  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [PERIOD_BITS-1:0] i_period,
  input  logic                   i_mode,
  input  logic                   i_reseed,
  output logic                   o_out,
  output logic                   o_step,
  output logic [LFSR_BITS-1:0]   o_lfsr_state
);

  logic [LFSR_BITS-1:0] r_lfsr;
  logic                 r_step;
  logic                 w_shift_req;

  noise_lfsr_multi_divider #(
    .PERIOD_BITS (PERIOD_BITS),
    .PRESCALE    (PRESCALE),
    .HALF_RATE   (HALF_RATE)
  ) u_divider (
    .clk         (clk),
    .reset       (reset),
    .i_enable    (i_enable),
    .i_period    (i_period),
    .i_clear     (i_reseed),
    .o_shift_req (w_shift_req)
  );

  // The OR with the all-zero flag forces a 1 in so the register can never lock up.
  function automatic logic noise_feedback(input logic [LFSR_BITS-1:0] state, input logic mode);
    logic is_zero;
    logic fb;
    is_zero = (state == {LFSR_BITS{1'b0}});
    if (mode == NOISE_PERIODIC) begin
      fb = state[0] | is_zero;
    end else begin
      fb = (^(state & TAP_MASK)) | is_zero;
    end
    return fb;
  endfunction

  // LFSR shift register and step pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= {LFSR_BITS{1'b0}};
      r_step <= 1'b0;
    end else if (i_reseed) begin
      r_lfsr <= SEED;
      r_step <= 1'b0;
    end else if (w_shift_req) begin
      r_lfsr <= {noise_feedback(r_lfsr, i_mode), r_lfsr[LFSR_BITS-1:1]};
      r_step <= 1'b1;
    end else begin
      r_step <= 1'b0;
    end
  end

  assign o_out        = r_lfsr[0] ^ OUT_INVERT;
  assign o_step       = r_step;
  assign o_lfsr_state = r_lfsr;

endmodule

// File: tb/tb_noise_lfsr_multi.sv
// Self-checking bench: three noise channel configurations against a behavioural model.
module tb_noise_lfsr_multi;

  logic        clk = 1'b0;
  logic        reset, enable, mode, reseed;
  logic [4:0]  period;
  logic [2:0]  out_v, step_v;
  logic [16:0] st0, st1, st2;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  noise_lfsr_multi #(.PRESCALE(1), .HALF_RATE(1'b0)) u_a (
    .clk(clk), .reset(reset), .i_enable(enable), .i_period(period), .i_mode(mode),
    .i_reseed(reseed), .o_out(out_v[0]), .o_step(step_v[0]), .o_lfsr_state(st0));
  noise_lfsr_multi #(.PRESCALE(1), .HALF_RATE(1'b1)) u_b (
    .clk(clk), .reset(reset), .i_enable(enable), .i_period(period), .i_mode(mode),
    .i_reseed(reseed), .o_out(out_v[1]), .o_step(step_v[1]), .o_lfsr_state(st1));
  noise_lfsr_multi u_c (
    .clk(clk), .reset(reset), .i_enable(enable), .i_period(period), .i_mode(mode),
    .i_reseed(reseed), .o_out(out_v[2]), .o_step(step_v[2]), .o_lfsr_state(st2));

  // Reference model: per instance, counts of enable ticks and divider wraps
  int ps [3] = '{1, 1, 16};
  int hr [3] = '{0, 1, 1};
  int m_lfsr [3], m_pre [3], m_cnt [3], m_wraps [3];
  bit m_step [3];

  typedef struct {
    int         inst;
    logic [4:0] per;
    int         first;
    int         spacing;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [16:0] dut_state(int k);
    case (k)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  function automatic int lfsr_next(int s, bit m);
    int fb;
    if (m) fb = s & 1;
    else   fb = $countones(s & 32'h9) % 2;
    if (s == 0) fb = 1;
    return (s >> 1) | (fb << 16);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_advance();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_lfsr[k] = 0; m_pre[k] = 0; m_cnt[k] = 0; m_wraps[k] = 0; m_step[k] = 0;
      end else if (reseed) begin
        m_lfsr[k] = 1; m_pre[k] = 0; m_cnt[k] = 0; m_wraps[k] = 0; m_step[k] = 0;
      end else begin
        bit sh;
        int pe;
        sh = 0;
        if (enable) begin
          if (m_pre[k] == ps[k] - 1) begin
            m_pre[k] = 0;
            pe = (period == 0) ? 1 : int'(period);
            if (m_cnt[k] >= pe - 1) begin
              m_cnt[k] = 0;
              m_wraps[k]++;
              sh = (hr[k] != 0) ? (m_wraps[k] % 2 == 1) : 1'b1;
            end else begin
              m_cnt[k]++;
            end
          end else begin
            m_pre[k]++;
          end
        end
        if (sh) m_lfsr[k] = lfsr_next(m_lfsr[k], mode);
        m_step[k] = sh;
      end
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lfsr%0d", k), 32'(dut_state(k)), 32'(m_lfsr[k]));
      chk($sformatf("step%0d", k), 32'(step_v[k]), 32'(m_step[k]));
      chk($sformatf("out%0d", k), 32'(out_v[k]), 32'((m_lfsr[k] & 1) ^ 1));
    end
  endtask

  task automatic wait_step(int k, int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step_v[k] && n < limit);
  endtask

  initial begin
    int n;
    logic [16:0] exp_seq [3];

    tbl[0] = '{0, 5'd5,  5,   5};
    tbl[1] = '{0, 5'd0,  1,   1};
    tbl[2] = '{0, 5'd1,  1,   1};
    tbl[3] = '{0, 5'd7,  7,   7};
    tbl[4] = '{1, 5'd5,  5,   10};
    tbl[5] = '{1, 5'd0,  1,   2};
    tbl[6] = '{1, 5'd3,  3,   6};
    tbl[7] = '{2, 5'd31, 496, 992};
    tbl[8] = '{2, 5'd2,  32,  64};

    reset = 1'b1; enable = 1'b0; mode = 1'b0; reseed = 1'b0; period = 5'd1;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_state", 32'(dut_state(k)), 32'h0);
      chk("rst_out", 32'(out_v[k]), 32'h1);
      chk("rst_step", 32'(step_v[k]), 32'h0);
    end

    // First shift out of the all-zero state
    enable = 1'b1;
    tick();
    chk("zero_recover", 32'(st0), 32'h10000);
    chk("zero_step", 32'(step_v[0]), 32'h1);
    chk("zero_out", 32'(out_v[0]), 32'h1);

    // White sequence from the seed
    reseed = 1'b1;
    tick();
    chk("reseed_state", 32'(st0), 32'h1);
    chk("reseed_step", 32'(step_v[0]), 32'h0);
    reseed = 1'b0;
    exp_seq = '{17'h10000, 17'h08000, 17'h04000};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("white_seq", 32'(st0), 32'(exp_seq[i]));
    end

    // Periodic: a single low out bit every 17 steps
    mode = 1'b1;
    reseed = 1'b1;
    tick();
    chk("per_out0", 32'(out_v[0]), 32'h0);
    reseed = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      tick();
      chk("per_out", 32'(out_v[0]), (i % 17 == 0) ? 32'h0 : 32'h1);
    end
    for (int i = 0; i < 5; i++) tick();
    mode = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Reseed collides with a pending shift
    reseed = 1'b1;
    tick();
    chk("collide_state", 32'(st0), 32'h1);
    chk("collide_step", 32'(step_v[0]), 32'h0);
    reseed = 1'b0;
    wait_step(0, 10, n);
    chk("collide_next", 32'(n), 32'd1);

    // Step timing table
    for (int r = 0; r < 9; r++) begin
      period = tbl[r].per;
      reseed = 1'b1;
      tick();
      reseed = 1'b0;
      wait_step(tbl[r].inst, tbl[r].first * 2 + 20, n);
      chk($sformatf("first_r%0d", r), 32'(n), 32'(tbl[r].first));
      wait_step(tbl[r].inst, tbl[r].spacing * 2 + 20, n);
      chk($sformatf("space_r%0d", r), 32'(n), 32'(tbl[r].spacing));
    end

    // Lower the period while the counter sits at 20
    period = 5'd31;
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    for (int i = 0; i < 320; i++) tick();
    period = 5'd2;
    wait_step(2, 100, n);
    chk("lower_first", 32'(n), 32'd16);
    wait_step(2, 200, n);
    chk("lower_space", 32'(n), 32'd64);

    // Reset mid-count
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("midrst_state", 32'(dut_state(k)), 32'h0);
      chk("midrst_out", 32'(out_v[k]), 32'h1);
    end
    reset = 1'b0;

    // Randomised traffic
    period = 5'd2;
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) period = 5'($urandom_range(0, 31));
      else if ($urandom_range(0, 29) == 0) period = 5'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      reseed = ($urandom_range(0, 199) == 0);
      reset  = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0; reseed = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
